// File: rtl/sda_pkg.sv
// Shared constants for the SDA input port: status bit positions, filter state
// codes and the line-select width.
package sda_pkg;

  localparam int unsigned READY_BIT   = 15;
  localparam int unsigned OVERRUN_BIT = 14;
  localparam int unsigned SEL_W       = 3;

  typedef enum logic [1:0] {
    ST_DIS = 2'b00,
    ST_ARM = 2'b01,
    ST_TRK = 2'b10
  } sda_state_e;

endpackage

// File: rtl/sda_in_filter.sv
// Bus synchronizer, line select and debounce filter. Emits a one-cycle
// capture pulse with the accepted level and the synchronized bus snapshot.
module sda_in_filter
  import sda_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_bus,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  input  logic             i_rearm,
  input  logic             i_rearm_en,
  output logic             o_cap_pulse,
  output logic             o_cap_level,
  output logic [7:0]       o_snapshot,
  output logic [1:0]       o_state
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ARM_W = $clog2(SYNC_STAGES);

  logic [7:0]       r_sync [SYNC_STAGES];
  sda_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ARM_W-1:0] r_arm_cnt, w_arm_nxt;
  logic             r_ref, w_ref_nxt;
  logic             w_cap;
  logic [7:0]       w_sync;
  logic             w_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_bus;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_s    = w_sync[i_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_DIS;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
      r_ref     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_arm_cnt <= w_arm_nxt;
      r_ref     <= w_ref_nxt;
    end
  end

  // The counter only ever reaches STABLE_CYCLES: that cycle either captures or clears.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arm_nxt   = r_arm_cnt;
    w_ref_nxt   = r_ref;
    w_cap       = 1'b0;
    if (i_rearm) begin
      w_state_nxt = i_rearm_en ? ST_ARM : ST_DIS;
      w_cnt_nxt   = '0;
      w_arm_nxt   = '0;
    end else if (!i_en) begin
      w_state_nxt = ST_DIS;
      w_cnt_nxt   = '0;
      w_arm_nxt   = '0;
    end else begin
      case (r_state)
        ST_DIS: begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = '0;
          w_arm_nxt   = '0;
        end
        ST_ARM: begin
          if (r_arm_cnt == ARM_W'(SYNC_STAGES - 1)) begin
            w_ref_nxt   = w_s;
            w_state_nxt = ST_TRK;
            w_arm_nxt   = '0;
          end else begin
            w_arm_nxt = r_arm_cnt + 1'b1;
          end
        end
        ST_TRK: begin
          if (w_s == r_ref) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(STABLE_CYCLES)) begin
            w_cap     = 1'b1;
            w_ref_nxt = w_s;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_DIS;
      endcase
    end
  end

  assign o_cap_pulse = w_cap;
  assign o_cap_level = w_s;
  assign o_snapshot  = w_sync;
  assign o_state     = r_state;

endmodule

// File: rtl/sda_in.sv
// LC-3 memory-mapped SDA input port: enable/select registers, captured data
// register and a READY/OVERRUN status word cleared by reading the data.
module sda_in
  import sda_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SDA_BUS,
  input  logic [15:0] MDR,
  input  logic        LD_SDAIER,
  input  logic        LD_SDAISEL,
  input  logic        RD_SDAIDR,
  output logic [15:0] SDAIER,
  output logic [15:0] SDAISEL,
  output logic [15:0] SDAIDR,
  output logic [15:0] SDAISR,
  output logic        ACK
);

  logic             r_ier;
  logic [SEL_W-1:0] r_sel;
  logic             r_level;
  logic [7:0]       r_snap;
  logic             r_ready;
  logic             r_ovr;
  logic             r_ack;

  logic             w_ld_ier, w_rearm, w_rearm_en;
  logic             w_cap, w_cap_level;
  logic [7:0]       w_snap;
  logic [1:0]       w_state;

  // Select load outranks enable load; either one restarts the filter.
  assign w_ld_ier   = LD_SDAIER & ~LD_SDAISEL;
  assign w_rearm    = LD_SDAISEL | (w_ld_ier & ~MDR[0]);
  assign w_rearm_en = LD_SDAISEL & r_ier;

  sda_in_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .i_bus      (SDA_BUS),
    .i_sel      (r_sel),
    .i_en       (r_ier),
    .i_rearm    (w_rearm),
    .i_rearm_en (w_rearm_en),
    .o_cap_pulse(w_cap),
    .o_cap_level(w_cap_level),
    .o_snapshot (w_snap),
    .o_state    (w_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ier   <= 1'b0;
      r_sel   <= '0;
      r_level <= 1'b0;
      r_snap  <= '0;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= LD_SDAISEL | LD_SDAIER;
      if (LD_SDAISEL) r_sel <= MDR[SEL_W-1:0];
      if (w_ld_ier)   r_ier <= MDR[0];
      if (w_cap) begin
        r_level <= w_cap_level;
        r_snap  <= w_snap;
        r_ready <= 1'b1;
        r_ovr   <= RD_SDAIDR ? 1'b0 : r_ready;
      end else if (RD_SDAIDR) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign SDAIER  = {15'b0, r_ier};
  assign SDAISEL = {{(16-SEL_W){1'b0}}, r_sel};
  assign SDAIDR  = {r_snap, 7'b0, r_level};
  assign ACK     = r_ack;

  always_comb begin
    SDAISR              = '0;
    SDAISR[READY_BIT]   = r_ready;
    SDAISR[OVERRUN_BIT] = r_ovr;
    SDAISR[1:0]         = w_state;
  end

endmodule

// File: tb/tb_sda_in.sv
// Directed checks of the register interface plus a randomized bus run scored
// against a run-length reference model of the debounce rule.
module tb_sda_in;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  SDA_BUS = '0;
  logic [15:0] MDR = '0;
  logic        LD_SDAIER = 1'b0, LD_SDAISEL = 1'b0, RD_SDAIDR = 1'b0;
  logic [15:0] SDAIER, SDAISEL, SDAIDR, SDAISR;
  logic        ACK;

  sda_in #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .SDA_BUS(SDA_BUS), .MDR(MDR),
    .LD_SDAIER(LD_SDAIER), .LD_SDAISEL(LD_SDAISEL), .RD_SDAIDR(RD_SDAIDR),
    .SDAIER(SDAIER), .SDAISEL(SDAISEL), .SDAIDR(SDAIDR), .SDAISR(SDAISR), .ACK(ACK)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a level is accepted once the synchronized line has differed
  // from the accepted level for STABLE+1 consecutive samples.
  typedef struct {
    int unsigned cyc;
    logic [15:0] idr;
    logic [15:0] sr;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  hq[$];
  int unsigned cyc = 0;
  bit          model_on = 0;
  bit          mon_on = 0;
  logic [2:0]  m_sel;
  logic        m_ref, m_ready, m_ovr;
  int unsigned m_run;

  always @(posedge clk) begin
    logic [7:0] sb;
    logic       lvl;
    exp_t       e;
    cyc++;
    hq.push_back(SDA_BUS);
    if (hq.size() > SYNC) begin
      sb = hq.pop_front();
      if (model_on) begin
        lvl = sb[m_sel];
        m_run = (lvl != m_ref) ? m_run + 1 : 0;
        if (m_run == STABLE + 1) begin
          m_ovr   = RD_SDAIDR ? 1'b0 : m_ready;
          m_ready = 1'b1;
          m_ref   = lvl;
          m_run   = 0;
          e.cyc = cyc;
          e.idr = {sb, 7'b0, lvl};
          e.sr  = {m_ready, m_ovr, 12'b0, 2'b10};
          expq.push_back(e);
        end else if (RD_SDAIDR) begin
          m_ready = 1'b0;
          m_ovr   = 1'b0;
        end
      end
    end
  end

  logic [15:0] mon_last = '0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && SDAIDR !== mon_last) begin
      if (expq.size() == 0) begin
        chk("sb_unexpected_capture", {16'h0, SDAIDR}, {16'h0, mon_last});
      end else begin
        e = expq.pop_front();
        chk("sb_cycle", cyc, e.cyc);
        chk("sb_idr", {16'h0, SDAIDR}, {16'h0, e.idr});
        chk("sb_sr", {16'h0, SDAISR}, {16'h0, e.sr});
      end
      mon_last = SDAIDR;
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] msk;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_ier", {16'h0, SDAIER}, 32'h0);
    chk("rst_sel", {16'h0, SDAISEL}, 32'h0);
    chk("rst_idr", {16'h0, SDAIDR}, 32'h0);
    chk("rst_sr", {16'h0, SDAISR}, 32'h0);
    chk("rst_ack", {31'h0, ACK}, 32'h0);

    LD_SDAISEL = 1'b1; MDR = 16'h0005;
    step(1);
    LD_SDAISEL = 1'b0;
    chk("sel_load", {16'h0, SDAISEL}, 32'h5);
    chk("sel_ack", {31'h0, ACK}, 32'h1);
    step(1);
    chk("ack_drop", {31'h0, ACK}, 32'h0);

    LD_SDAIER = 1'b1; MDR = 16'h0001;
    step(1);
    LD_SDAIER = 1'b0;
    chk("ier_load", {16'h0, SDAIER}, 32'h1);
    step(10);
    chk("trk_state", {16'h0, SDAISR}, 32'h0002);

    SDA_BUS = 8'h20;
    step(18);
    chk("latency_not_yet", {31'h0, SDAISR[15]}, 32'h0);
    step(1);
    chk("latency_ready", {16'h0, SDAISR}, 32'h8002);
    chk("latency_idr", {16'h0, SDAIDR}, 32'h2001);

    RD_SDAIDR = 1'b1; step(1); RD_SDAIDR = 1'b0;
    chk("rd_clear", {16'h0, SDAISR}, 32'h0002);

    SDA_BUS = 8'h00; step(10); SDA_BUS = 8'h20; step(30);
    chk("glitch_idr", {16'h0, SDAIDR}, 32'h2001);
    chk("glitch_sr", {16'h0, SDAISR}, 32'h0002);

    SDA_BUS = 8'h00; step(25);
    chk("first_cap_idr", {16'h0, SDAIDR}, 32'h0000);
    chk("first_cap_sr", {16'h0, SDAISR}, 32'h8002);
    SDA_BUS = 8'h20; step(25);
    chk("overrun_idr", {16'h0, SDAIDR}, 32'h2001);
    chk("overrun_sr", {16'h0, SDAISR}, 32'hC002);
    RD_SDAIDR = 1'b1; step(1); RD_SDAIDR = 1'b0;
    chk("overrun_rd", {16'h0, SDAISR}, 32'h0002);

    SDA_BUS = 8'h00; step(25);
    SDA_BUS = 8'h20; step(18);
    RD_SDAIDR = 1'b1; step(1); RD_SDAIDR = 1'b0;
    chk("rd_cap_sr", {16'h0, SDAISR}, 32'h8002);
    chk("rd_cap_idr", {16'h0, SDAIDR}, 32'h2001);

    SDA_BUS = 8'h00; step(8);
    LD_SDAISEL = 1'b1; MDR = 16'h0005; step(1); LD_SDAISEL = 1'b0;
    chk("resel_arm0", {16'h0, SDAISR}, 32'h8001);
    step(1);
    chk("resel_arm1", {16'h0, SDAISR}, 32'h8001);
    step(1);
    chk("resel_trk", {16'h0, SDAISR}, 32'h8002);
    step(30);
    chk("resel_nocap", {16'h0, SDAIDR}, 32'h2001);
    SDA_BUS = 8'h20; step(8);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("midrst_idr", {16'h0, SDAIDR}, 32'h0);
    chk("midrst_sr", {16'h0, SDAISR}, 32'h0);
    chk("midrst_ier", {16'h0, SDAIER}, 32'h0);
    chk("midrst_sel", {16'h0, SDAISEL}, 32'h0);
    step(30);
    chk("midrst_idle", {16'h0, SDAIDR}, 32'h0);

    // Random phase: line bit starts at 0 so every capture toggles SDAIDR[0].
    m_sel = 3'($urandom_range(0, 7));
    msk = 8'h01 << m_sel;
    b = 8'($urandom_range(0, 255)) & ~msk;
    SDA_BUS = b;
    LD_SDAISEL = 1'b1; MDR = {13'h0, m_sel}; step(1); LD_SDAISEL = 1'b0;
    LD_SDAIER = 1'b1; MDR = 16'h0001; step(1); LD_SDAIER = 1'b0;
    step(10);
    m_ref = 1'b0; m_ready = 1'b0; m_ovr = 1'b0; m_run = 0;
    mon_last = '0;
    model_on = 1; mon_on = 1;
    for (int seg = 0; seg < 60; seg++) begin
      SDA_BUS = 8'($urandom_range(0, 255));
      for (int k = 0, n = $urandom_range(1, 30); k < n; k++) begin
        RD_SDAIDR = ($urandom_range(0, 7) == 0);
        step(1);
      end
    end
    RD_SDAIDR = 1'b0;
    step(40);
    mon_on = 0;
    chk("sb_drain", expq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
